memory_stage: RTL and testbench

// - MEM stage of the RV32 pipeline. It sits directly downstream of the EX stage.
// - Consumes the ALU result (the address) and the forwarded store data from EX/MEM.
// - Runs one load/store on a req/gnt/rvalid data-memory bus.
// - Performs byte-lane steering and load sign/zero extension.
// - Stalls the pipeline while the bus is busy and produces a registered write-back result.

---
 rtl/dmem_if.sv | 24 ++
 rtl/memory_stage.sv | 200 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// Handshake: the master holds req/we/be/addr/wdata stable from the first req cycle
// through the cycle where gnt=1, which completes the request phase. For loads, rvalid
// pulses once later with rdata valid in that same cycle. gnt/rvalid carry no back-pressure.
interface dmem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// RV32 MEM stage: one load/store per instruction on the req/gnt/rvalid bus, with
// lane steering, load extension, timeout fault, flush handling and a registered result.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_data,
  input  logic [31:0] memory_data,
  input  logic        flush,
  dmem_if.master      dmem,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        mem_exception,
  output logic [1:0]  mem_exception_code,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT_RSP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kill_q, kill_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          wb_valid_q, wb_valid_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          exc_q, exc_d;
  logic [1:0]    code_q, code_d;

  logic          is_mem, illegal, misaligned, timed_out;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;

  assign is_mem     = mem_read | mem_write;
  assign illegal    = mem_write ? (funct3[2] | (funct3[1:0] == 2'b11))
                                : !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = ((funct3[1:0] == 2'b01) && alu_data[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_data[1:0] != 2'b00));
  assign timed_out  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Load lane select uses the latched byte offset and width.
  always_comb begin
    ld_byte  = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = dmem.dmem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val = dmem.dmem_rdata;
    case (funct3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_val = {24'b0, ld_byte};
      3'b101:  load_val = {16'b0, ld_half};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    exc_d      = 1'b0;
    code_d     = code_q;
    stall      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in && !flush) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_data;
          end else if (illegal || misaligned) begin
            wb_valid_d = 1'b1;
            wb_data_d  = 32'd0;
            exc_d      = 1'b1;
            code_d     = illegal ? 2'b10 : 2'b00;
          end else begin
            stall    = 1'b1;
            state_d  = S_REQ;
            cnt_d    = '0;
            kill_d   = 1'b0;
            we_d     = mem_write;
            addr_d   = alu_data;
            funct3_d = funct3;
            case (funct3[1:0])
              2'b00:   begin be_d = 4'b0001 << alu_data[1:0]; wdata_d = {4{memory_data[7:0]}}; end
              2'b01:   begin be_d = alu_data[1] ? 4'b1100 : 4'b0011; wdata_d = {2{memory_data[15:0]}}; end
              default: begin be_d = 4'b1111; wdata_d = memory_data; end
            endcase
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dmem.dmem_gnt) begin
          kill_d = kill_q | flush;
          if (we_q) begin
            stall   = 1'b0;
            state_d = S_IDLE;
            if (!(kill_q || flush)) begin
              wb_valid_d = 1'b1;
              wb_data_d  = 32'd0;
            end
          end else begin
            state_d = S_WAIT_RSP;
            cnt_d   = '0;
          end
        end else if (flush) begin
          // Killed before the bus took it: nothing to complete, let the pipeline move.
          stall   = 1'b0;
          state_d = S_IDLE;
        end else if (timed_out) begin
          stall      = 1'b0;
          state_d    = S_IDLE;
          wb_valid_d = !kill_q;
          wb_data_d  = 32'd0;
          exc_d      = !kill_q;
          code_d     = 2'b01;
        end
      end
      S_WAIT_RSP: begin
        stall  = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        kill_d = kill_q | flush;
        if (dmem.dmem_rvalid) begin
          stall      = 1'b0;
          state_d    = S_IDLE;
          wb_valid_d = !(kill_q || flush);
          wb_data_d  = load_val;
        end else if (timed_out) begin
          stall      = 1'b0;
          state_d    = S_IDLE;
          wb_valid_d = !(kill_q || flush);
          wb_data_d  = 32'd0;
          exc_d      = !(kill_q || flush);
          code_d     = 2'b01;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      exc_q      <= 1'b0;
      code_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      exc_q      <= exc_d;
      code_q     <= code_d;
    end
  end

  assign dmem.dmem_req      = (state_q == S_REQ);
  assign dmem.dmem_we       = we_q;
  assign dmem.dmem_be       = be_q;
  assign dmem.dmem_addr     = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata    = wdata_q;
  assign wb_valid           = wb_valid_q;
  assign wb_data            = wb_data_q;
  assign mem_exception      = exc_q;
  assign mem_exception_code = code_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: a bus-responder task drives each instruction and
// a reference model predicts lane steering and write-back results into a queue.
module tb_memory_stage;
  localparam int T = 4;

  logic        clk;
  logic        reset_n;
  logic        valid_in, mem_read, mem_write, flush;
  logic [2:0]  funct3;
  logic [31:0] alu_data, memory_data;
  logic        stall, wb_valid, mem_exception;
  logic [31:0] wb_data;
  logic [1:0]  mem_exception_code, dbg_state;

  dmem_if dmem();

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_data(alu_data),
    .memory_data(memory_data), .flush(flush), .dmem(dmem), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .mem_exception(mem_exception),
    .mem_exception_code(mem_exception_code), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];   // {exception, code, data}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every write-back pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_wb", 32'd1, 32'd0);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        chk("wb_exc", {31'd0, mem_exception}, {31'd0, e[34]});
        if (e[34]) chk("wb_code", {30'd0, mem_exception_code}, {30'd0, e[33:32]});
        else       chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  // reference model from the architectural rules
  function automatic void ref_op(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                                 output bit bus, output logic [34:0] imm, output logic [31:0] load_res,
                                 output logic [3:0] be, output logic [31:0] wd);
    int size, off;
    bit ok;
    logic [31:0] mask, v;
    off = int'(a % 4);
    case (f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    ok = (size != 0) && !(st && f3[2]) && !(ld && f3 == 3'b110);
    bus = 0; imm = '0; load_res = '0; be = '0; wd = '0;
    if (!ld && !st) imm = {3'b000, a};
    else if (!ok) imm = {1'b1, 2'd2, 32'd0};
    else if (off % size != 0) imm = {1'b1, 2'd0, 32'd0};
    else begin
      bus  = 1;
      be   = 4'(((1 << size) - 1) << off);
      mask = (size == 4) ? 32'hffff_ffff : ((32'd1 << (8 * size)) - 1);
      wd   = (size == 1) ? (d & mask) * 32'h0101_0101 :
             (size == 2) ? (d & mask) * 32'h0001_0001 : d;
      v    = (rd >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      load_res = v;
    end
  endfunction

  // driver: gdly/rdly = bus cycles before gnt/rvalid (>=T means never);
  // fl_cyc = cycle index of the op at which flush pulses (0 = issue cycle, -1 = none)
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int gdly, input int rdly, input int fl_cyc);
    bit bus, killed;
    logic [34:0] imm;
    logic [31:0] lres, wd;
    logic [3:0] be;
    int phase, c, k;
    ref_op(ld, st, f3, a, d, rd, bus, imm, lres, be, wd);
    valid_in = 1'b1; mem_read = ld; mem_write = st; funct3 = f3;
    alu_data = a; memory_data = d;
    killed = (fl_cyc == 0);
    @(negedge clk);
    flush = (fl_cyc == 0);
    #1;
    chk("idle_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("idle_stall", {31'd0, stall}, {31'd0, bus && !killed});
    if (!bus && !killed) exp_q.push_back(imm);
    @(posedge clk); #1;
    flush = 1'b0;
    phase = (bus && !killed) ? 1 : 3;
    c = 0; k = 0;
    for (int guard = 0; guard < 4 * T + 8 && phase != 3; guard++) begin
      @(negedge clk);
      k++;
      flush = (k == fl_cyc);
      if (phase == 1) begin
        dmem.dmem_gnt = (c == gdly);
        #1;
        chk("req_hi", {31'd0, dmem.dmem_req}, 32'd1);
        chk("req_addr", dmem.dmem_addr, {a[31:2], 2'b00});
        chk("req_we", {31'd0, dmem.dmem_we}, {31'd0, st});
        chk("req_be", {28'd0, dmem.dmem_be}, {28'd0, be});
        if (st) chk("req_wdata", dmem.dmem_wdata, wd);
        if (dmem.dmem_gnt) begin
          if (flush) killed = 1;
          chk("stall_gnt", {31'd0, stall}, {31'd0, ld});
          if (st) begin
            phase = 3;
            if (!killed) exp_q.push_back({1'b0, 2'd0, 32'd0});
          end else begin
            phase = 2;
            c = -1;
          end
        end else if (flush) begin
          chk("stall_flush", {31'd0, stall}, 32'd0);
          phase = 3;
        end else if (c == T - 1) begin
          chk("stall_tmo", {31'd0, stall}, 32'd0);
          phase = 3;
          exp_q.push_back({1'b1, 2'd1, 32'd0});
        end else begin
          chk("stall_req", {31'd0, stall}, 32'd1);
        end
      end else begin
        dmem.dmem_rvalid = (c == rdly);
        dmem.dmem_rdata  = dmem.dmem_rvalid ? rd : $urandom;
        #1;
        if (flush) killed = 1;
        chk("wait_req", {31'd0, dmem.dmem_req}, 32'd0);
        if (dmem.dmem_rvalid) begin
          chk("stall_rsp", {31'd0, stall}, 32'd0);
          phase = 3;
          if (!killed) exp_q.push_back({1'b0, 2'd0, lres});
        end else if (c == T - 1) begin
          chk("stall_tmo", {31'd0, stall}, 32'd0);
          phase = 3;
          if (!killed) exp_q.push_back({1'b1, 2'd1, 32'd0});
        end else begin
          chk("stall_wait", {31'd0, stall}, 32'd1);
        end
      end
      c++;
      @(posedge clk); #1;
      dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; flush = 1'b0;
    end
    if (phase != 3) chk("op_bound", 32'd0, 32'd1);
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    funct3 = 3'd0; alu_data = '0; memory_data = '0;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
    #3;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", {31'd0, mem_exception}, 32'd0);
    chk("rst_code", {30'd0, mem_exception_code}, 32'd0);
    chk("rst_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // directed cases
    run_op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h8000_0000, 0, 0, -1);  // LB
    run_op(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h8000_0000, 1, 2, -1);  // LBU
    run_op(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 0, -1);  // SH, late gnt
    run_op(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 0, -1);          // misaligned LW
    run_op(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 99, 0, -1);         // gnt timeout
    run_op(1, 0, 3'b010, 32'h0000_3004, 32'h0, 32'h0, 3, 0, 2);           // flush in REQ
    run_op(0, 0, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 0, 0, -1);          // ADD
    run_op(0, 0, 3'b000, 32'h0000_0077, 32'h0, 32'h0, 0, 0, -1);          // back-to-back
    run_op(1, 0, 3'b010, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 0, 1, -1);
    run_op(0, 1, 3'b010, 32'h0000_400C, 32'hDEAD_BEEF, 32'h0, 0, 0, -1);
    run_op(0, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 1, 0, 2);   // flush with gnt
    run_op(1, 0, 3'b001, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 0, 2, 3);   // flush in WAIT_RSP
    run_op(1, 0, 3'b001, 32'h0000_5002, 32'h0, 32'h0, 0, 0, 0);           // flush in IDLE
    run_op(0, 1, 3'b100, 32'h0000_6000, 32'h1, 32'h0, 0, 0, -1);          // illegal store
    run_op(1, 0, 3'b011, 32'h0000_6000, 32'h0, 32'h0, 0, 0, -1);          // illegal load
    run_op(1, 0, 3'b101, 32'h0000_6002, 32'h0, 32'h0, 0, 99, -1);         // rvalid timeout
    run_op(1, 0, 3'b001, 32'h0000_6002, 32'h0, 32'hF00D_1234, 2, 0, -1);  // LH upper half

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      int kind, gd, rdl, fc;
      kind = $urandom_range(0, 4);
      ld = (kind == 1 || kind == 2);
      st = (kind >= 3);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                        : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01 ? {a[1], 1'b0} : a[1:0]);
      gd  = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 3);
      rdl = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 3);
      fc  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      run_op(ld, st, f3, a, $urandom, $urandom, gd, rdl, fc);
    end

    // reset while waiting for a load response
    run_op(0, 0, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 0, 0, -1);
    valid_in = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_data = 32'h0000_7000;
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read = 1'b0;
    @(negedge clk); dmem.dmem_gnt = 1'b1;
    @(posedge clk); #1; dmem.dmem_gnt = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_exc", {31'd0, mem_exception}, 32'd0);
    chk("arst_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    dmem.dmem_rvalid = 1'b1;  // stale response after reset must be ignored
    @(posedge clk); #1;
    dmem.dmem_rvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pending", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
